// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART_TX serializer between NUM_REQ byte sources. Sources are
// served round-robin. Each granted byte is handed to UART_TX with a one-cycle
// o_TX_DV pulse. The block then waits for i_TX_DONE and reports completion on
// o_DONE. A watchdog aborts a transfer that never completes and reports it on
// o_ERR.
//
// Optional feature:
//   UART_TX_ARB_PRIO_EN - When this macro is defined, source 0 has absolute
//                         priority and does not move the round-robin pointer.
//                         When it is undefined, the block uses pure
//                         round-robin across all sources.
//
// Parameters:
//   NUM_REQ      number of requesters (2..8)
//   TIMEOUT_CYC  cycles allowed in WAIT_DONE before abort
//
// Ports:
//   i_CLK       system clock, posedge
//   i_RST       async reset, active-high
//   i_REQ       per-source request level, held until granted
//   i_REQ_BYTE  byte k at [8k+7:8k]
//   o_GRANT     one-hot 1-cycle pulse, byte k accepted (coincides with o_TX_DV)
//   o_TX_DV     1-cycle strobe to UART_TX
//   o_TX_BYTE   byte to UART_TX, held until the next issue
//   i_TX_DONE   completion strobe from UART_TX
//   o_DONE      1-cycle pulse, granted byte fully sent
//   o_DONE_ID   source index of current/last transfer
//   o_ERR       1-cycle pulse, watchdog abort
//   o_BUSY      high whenever the FSM is not in IDLE
//
// State table:
//   IDLE      | arbitrate; latch winner, byte and id
//   ISSUE     | fire o_TX_DV/o_GRANT (registered), clear watchdog
//   WAIT_DONE | wait for i_TX_DONE or watchdog expiry, then advance pointer
//
// All strobes are registered. As a result, o_TX_DV/o_GRANT are visible in the
// cycle after ISSUE, which is the first WAIT_DONE cycle. Likewise, o_DONE/o_ERR
// are visible in the first IDLE cycle after the transfer ends.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic [NUM_REQ-1:0]   i_REQ,
  input  logic [8*NUM_REQ-1:0] i_REQ_BYTE,
  output logic [NUM_REQ-1:0]   o_GRANT,
  output logic                 o_TX_DV,
  output logic [7:0]           o_TX_BYTE,
  input  logic                 i_TX_DONE,
  output logic                 o_DONE,
  output logic [2:0]           o_DONE_ID,
  output logic                 o_ERR,
  output logic                 o_BUSY
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      win_q, win_d;
  logic [7:0]         byte_q, byte_d;
  logic [2:0]         id_q, id_d;
  logic [WW-1:0]      wdog_q, wdog_d;
  logic               dv_q, dv_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [7:0]         req_bytes [NUM_REQ];
  logic               found;
  logic [PW-1:0]      pick;
  logic [PW-1:0]      idx;
  logic [PW-1:0]      ptr_adv;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_bytes[k] = i_REQ_BYTE[8*k +: 8];
    end
  end

  // First requester at or above the pointer, wrapping to 0.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PW'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && i_REQ[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
`ifdef UART_TX_ARB_PRIO_EN
    if (i_REQ[0]) begin
      found = 1'b1;
      pick  = '0;
    end
`endif
  end

  // Pointer moves past the finished source. In priority mode, a source 0
  // transfer leaves the pointer alone, so the others keep their rotation.
  always_comb begin
    ptr_adv = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
`ifdef UART_TX_ARB_PRIO_EN
    if (win_q == '0) begin
      ptr_adv = ptr_q;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    byte_d  = byte_q;
    id_d    = id_q;
    wdog_d  = wdog_q;
    dv_d    = 1'b0;
    grant_d = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          win_d   = pick;
          byte_d  = req_bytes[pick];
          id_d    = 3'(pick);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        dv_d          = 1'b1;
        grant_d[win_q] = 1'b1;
        wdog_d        = '0;
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        // Done takes precedence over a coincident watchdog expiry.
        if (i_TX_DONE) begin
          done_d  = 1'b1;
          ptr_d   = ptr_adv;
          state_d = ST_IDLE;
        end else if (wdog_q >= WD_LAST) begin
          err_d   = 1'b1;
          ptr_d   = ptr_adv;
          state_d = ST_IDLE;
        end else begin
          // Only increments below WD_LAST, so it saturates and never wraps.
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      byte_q  <= '0;
      id_q    <= '0;
      wdog_q  <= '0;
      dv_q    <= 1'b0;
      grant_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      byte_q  <= byte_d;
      id_q    <= id_d;
      wdog_q  <= wdog_d;
      dv_q    <= dv_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_GRANT   = grant_q;
  assign o_TX_DV   = dv_q;
  assign o_TX_BYTE = byte_q;
  assign o_DONE    = done_q;
  assign o_DONE_ID = id_q;
  assign o_ERR     = err_q;
  assign o_BUSY    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int TO  = 50;
  localparam int DLY = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_byte;
  logic [3:0]  grant;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_done;
  logic        done;
  logic [2:0]  done_id;
  logic        err;
  logic        busy;

  uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .i_CLK(clk), .i_RST(rst), .i_REQ(req), .i_REQ_BYTE(req_byte),
    .o_GRANT(grant), .o_TX_DV(tx_dv), .o_TX_BYTE(tx_byte),
    .i_TX_DONE(tx_done), .o_DONE(done), .o_DONE_ID(done_id),
    .o_ERR(err), .o_BUSY(busy)
  );

  always #5 clk = ~clk;

  int         pend [NR];
  logic [7:0] src_byte [NR];
  logic       done_m = 1'b0;
  logic       done_s = 1'b0;
  bit         auto_done = 1'b1;

  assign tx_done = done_m | done_s;

  always_comb begin
    req      = '0;
    req_byte = '0;
    for (int k = 0; k < NR; k++) begin
      req[k]            = (pend[k] != 0);
      req_byte[8*k +: 8] = src_byte[k];
    end
  end

  typedef struct {
    logic [3:0] grant;
    logic [7:0] byt;
    logic [2:0] id;
  } tx_t;

  tx_t        exp_tx[$];
  logic [2:0] exp_done[$];
  logic [2:0] exp_err[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_tx(input int k, input logic [7:0] b);
    tx_t t;
    t.grant = 4'(1 << k);
    t.byt   = b;
    t.id    = 3'(k);
    exp_tx.push_back(t);
    exp_done.push_back(3'(k));
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe.
  initial begin
    tx_t        e;
    logic [2:0] d;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tx_dv) begin
          if (exp_tx.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL tx_unexpected: got grant %b want none", grant);
          end else begin
            e = exp_tx.pop_front();
            chk("tx_grant", 32'(grant), 32'(e.grant));
            chk("tx_byte", 32'(tx_byte), 32'(e.byt));
            chk("tx_id", 32'(done_id), 32'(e.id));
          end
        end else if (grant != 4'b0) begin
          n_cmp++; n_bad++;
          $display("FAIL grant_without_dv: got %b want 0", grant);
        end
        if (done) begin
          if (exp_done.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done_unexpected: got id %0d want none", done_id);
          end else begin
            d = exp_done.pop_front();
            chk("done_id", 32'(done_id), 32'(d));
          end
        end
        if (err) begin
          if (exp_err.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL err_unexpected: got id %0d want none", done_id);
          end else begin
            d = exp_err.pop_front();
            chk("err_id", 32'(done_id), 32'(d));
            chk("err_busy", 32'(busy), 32'(0));
          end
        end
      end
    end
  end

  // UART_TX stand-in: done pulse DLY cycles after each o_TX_DV.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (tx_dv && auto_done) begin
        repeat (DLY) @(posedge clk);
        #1; done_m = 1'b1;
        @(posedge clk);
        #1; done_m = 1'b0;
      end
    end
  end

  // Sources drop their request once their pending count is consumed.
  initial begin
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < NR; k++) begin
        if (grant[k] && pend[k] > 0) pend[k]--;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic int pend_sum();
    int s = 0;
    for (int k = 0; k < NR; k++) s += pend[k];
    return s;
  endfunction

  task automatic wait_quiet(input string name, input int budget);
    int c = 0;
    while ((busy || exp_tx.size() != 0 || exp_done.size() != 0 ||
            exp_err.size() != 0 || pend_sum() != 0) && c < budget) begin
      @(posedge clk); #2;
      c++;
    end
    n_cmp++;
    if (c >= budget) begin
      n_bad++;
      $display("FAIL %s: got still busy after %0d cycles want idle", name, c);
    end
    cyc(2);
  endtask

  task automatic wait_dv(input string name);
    int c = 0;
    while (!tx_dv && c < 100) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (!tx_dv) begin
      n_bad++;
      $display("FAIL %s: got no tx_dv want tx_dv", name);
    end
  endtask

  initial begin
    #500us;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    bit saw;
    rst = 1'b1;
    for (int k = 0; k < NR; k++) begin
      pend[k]     = 0;
      src_byte[k] = 8'h00;
    end
    cyc(3);
    chk("rst_dv", 32'(tx_dv), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_byte", 32'(tx_byte), 0);
    chk("rst_id", 32'(done_id), 0);
    rst = 1'b0;
    cyc(2);

    // Fairness: all four requesting, source 0 wants two bytes.
    for (int k = 0; k < NR; k++) src_byte[k] = 8'hA0 + 8'(k);
`ifdef UART_TX_ARB_PRIO_EN
    push_tx(0, 8'hA0); push_tx(0, 8'hA0); push_tx(1, 8'hA1);
    push_tx(2, 8'hA2); push_tx(3, 8'hA3);
`else
    push_tx(0, 8'hA0); push_tx(1, 8'hA1); push_tx(2, 8'hA2);
    push_tx(3, 8'hA3); push_tx(0, 8'hA0);
`endif
    pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
    wait_quiet("fair_quiet", 400);

    // Single request from source 2, with latency checks.
    src_byte[2] = 8'h05;
    push_tx(2, 8'h05);
    pend[2] = 1;
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (!tx_dv && c < 10);
    chk("dv_latency", 32'(c), 2);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!tx_done && c < 50);
    @(negedge clk);
    chk("done_latency", 32'(done), 1);
    cyc(1);
    wait_quiet("single_quiet", 100);

    // Stray done in IDLE: nothing happens, pointer stays at 3.
    saw = 1'b0;
    done_s = 1'b1;
    @(negedge clk); saw |= done | busy;
    cyc(1);
    done_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      saw |= done | busy;
    end
    chk("stray_done", 32'(saw), 0);
    cyc(1);
    src_byte[1] = 8'h11; src_byte[3] = 8'h33;
    push_tx(3, 8'h33); push_tx(1, 8'h11);
    pend[1] = 1; pend[3] = 1;
    wait_quiet("stray_quiet", 200);

    // Watchdog abort from source 0.
    auto_done = 1'b0;
    src_byte[0] = 8'h3C;
    begin
      tx_t t;
      t.grant = 4'b0001; t.byt = 8'h3C; t.id = 3'd0;
      exp_tx.push_back(t);
    end
    exp_err.push_back(3'd0);
    pend[0] = 1;
    wait_dv("to_dv");
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!err && c < 100);
    chk("err_latency", 32'(c), TO);
    cyc(1);
    auto_done = 1'b1;
    wait_quiet("to_quiet", 100);
    src_byte[1] = 8'h61; src_byte[0] = 8'h60;
`ifdef UART_TX_ARB_PRIO_EN
    push_tx(1, 8'h61);
    pend[1] = 1;
`else
    push_tx(1, 8'h61); push_tx(0, 8'h60);
    pend[0] = 1; pend[1] = 1;
`endif
    wait_quiet("after_to_quiet", 200);

    // Reset mid-transfer.
    auto_done = 1'b0;
    src_byte[3] = 8'h77;
    begin
      tx_t t;
      t.grant = 4'b1000; t.byt = 8'h77; t.id = 3'd3;
      exp_tx.push_back(t);
    end
    pend[3] = 1;
    wait_dv("rstmid_dv");
    cyc(3);
    rst = 1'b1;
    #1;
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_byte", 32'(tx_byte), 0);
    chk("rstmid_id", 32'(done_id), 0);
    chk("rstmid_dv", 32'(tx_dv), 0);
    cyc(2);
    rst = 1'b0;
    auto_done = 1'b1;
    cyc(1);
    src_byte[2] = 8'h5A;
    push_tx(2, 8'h5A);
    pend[2] = 1;
    wait_quiet("rstmid_quiet", 200);

`ifdef UART_TX_ARB_PRIO_EN
    // Source 0 jumps the queue and leaves the pointer where it was.
    for (int k = 0; k < NR; k++) src_byte[k] = 8'hC0 + 8'(k);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    push_tx(1, 8'hC1);
    pend[1] = 1; pend[2] = 1; pend[3] = 1;
    wait_dv("prio_dv");
    cyc(1);
    push_tx(0, 8'hC0); push_tx(2, 8'hC2); push_tx(3, 8'hC3);
    pend[0] = 1;
    wait_quiet("prio_quiet", 400);
`endif

    chk("left_tx", 32'(exp_tx.size()), 0);
    chk("left_done", 32'(exp_done.size()), 0);
    chk("left_err", 32'(exp_err.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
